// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte-to-frame deframer.
package uart_pkg;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Deframer states, in wire order of the frame fields.
    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } frame_state_t;

endpackage

// File: rtl/uart_frame_rx.sv
// Deframer: hunts for SYNC, buffers one LEN-prefixed XOR-checked frame and
// releases the payload as a valid/ready stream once the checksum verifies.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       frame_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic       busy
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [LW-1:0] ONE       = LW'(1);

    frame_state_t  state;
    frame_state_t  state_next;

    logic [LW-1:0] len;
    logic [LW-1:0] wr_idx;
    logic [LW-1:0] rd_idx;
    logic [7:0]    chk;
    logic [TW-1:0] tmr;
    logic          arm;
    logic [7:0]    mem [MAX_LEN];

    logic          timed;
    logic          tmo_hit;
    logic          take;
    logic          ev_ok;
    logic          ev_chk;
    logic          ev_len;
    logic          ev_ovr;

    // DRAIN presents data one cycle after entry so frame_ok leads m_valid.
    assign m_valid     = (state == DRAIN) && arm;
    assign m_last      = m_valid && (rd_idx == len - ONE);
    assign m_data      = m_valid ? mem[rd_idx[IW-1:0]] : '0;
    assign busy        = (state != HUNT);
    assign take        = m_valid && m_ready;

    // A byte on the boundary cycle wins over the timeout.
    assign timed       = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    assign tmo_hit     = timed && !rx_valid && (tmr == TMO_LIMIT);
    assign err_timeout = tmo_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and single-cycle event decisions.
    always_comb begin
        state_next = state;
        ev_ok      = 1'b0;
        ev_chk     = 1'b0;
        ev_len     = 1'b0;
        ev_ovr     = 1'b0;
        case (state)
            HUNT: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
                        ev_len     = 1'b1;
                        state_next = HUNT;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    state_next = HUNT;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    if (wr_idx == len - ONE) begin
                        state_next = CHK;
                    end
                end else if (tmo_hit) begin
                    state_next = HUNT;
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk) begin
                        ev_ok      = 1'b1;
                        state_next = DRAIN;
                    end else begin
                        ev_chk     = 1'b1;
                        state_next = HUNT;
                    end
                end else if (tmo_hit) begin
                    state_next = HUNT;
                end
            end
            DRAIN: begin
                ev_ovr = rx_valid;
                if (take && m_last) begin
                    state_next = HUNT;
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // Frame bookkeeping: length, indices, running checksum, timeout, pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            len         <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            chk         <= '0;
            tmr         <= '0;
            arm         <= 1'b0;
            frame_ok    <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            frame_ok    <= ev_ok;
            err_chk     <= ev_chk;
            err_len     <= ev_len;
            err_overrun <= ev_ovr;
            arm         <= (state == DRAIN) && (state_next == DRAIN);

            if (rx_valid || !timed) begin
                tmr <= '0;
            end else if (tmr != TMO_LIMIT) begin
                tmr <= tmr + TW'(1);
            end

            case (state)
                LEN: begin
                    if (rx_valid) begin
                        len    <= rx_data[LW-1:0];
                        chk    <= rx_data;
                        wr_idx <= '0;
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        chk    <= chk ^ rx_data;
                        wr_idx <= wr_idx + ONE;
                    end
                end
                CHK: begin
                    if (ev_ok) begin
                        rd_idx <= '0;
                    end
                end
                DRAIN: begin
                    if (take && !m_last) begin
                        rd_idx <= rd_idx + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Payload buffer; contents are meaningless until a frame is written.
    always_ff @(posedge clk) begin
        if ((state == PAYLOAD) && rx_valid) begin
            mem[wr_idx[IW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed scenarios plus randomized
// frames against a frame-level reference (XOR of LEN and payload, expected
// byte queue, expected pulse counts and cycle offsets).
module tb_uart_frame_rx;

    localparam int unsigned MAXL = 12;
    localparam int unsigned TMO  = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       frame_ok;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;
    logic       busy;

    uart_frame_rx #(
        .MAX_LEN(MAXL),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_last(m_last),
        .m_ready(m_ready),
        .frame_ok(frame_ok),
        .err_chk(err_chk),
        .err_len(err_len),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Observation counters filled by the monitor.
    int n_ok = 0, n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;
    int n_multi = 0, n_unstable = 0;
    int ok_cyc = -1, to_cyc = -1, chk_cyc = -1, first_v_cyc = -1;
    int first_x_cyc = -1, last_x_cyc = -1;
    logic chk_busy = 1'b0;
    logic [8:0] got[$];
    logic pv = 1'b0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;

    // Baselines for per-step deltas.
    int b_ok, b_chk, b_len, b_to, b_ovr;
    int last_cyc = 0;

    always @(negedge clk) begin
        if (frame_ok) begin
            n_ok++;
            ok_cyc = cyc;
            first_v_cyc = -1;
        end
        if (err_chk) begin
            n_chk++;
            chk_cyc = cyc;
            chk_busy = busy;
        end
        if (err_len) n_len++;
        if (err_timeout) begin
            n_to++;
            to_cyc = cyc;
        end
        if (err_overrun) n_ovr++;
        if (int'(err_chk) + int'(err_len) + int'(err_timeout) + int'(err_overrun) > 1)
            n_multi++;
        if (m_valid && first_v_cyc < 0) first_v_cyc = cyc;
        if (pv && (!m_valid || m_data !== pd || m_last !== pl)) n_unstable++;
        pv = m_valid && !m_ready && !rst;
        pd = m_data;
        pl = m_last;
        if (m_valid && m_ready) begin
            if (got.size() == 0) first_x_cyc = cyc;
            got.push_back({m_last, m_data});
            if (m_last) last_x_cyc = cyc;
        end
    end

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] l, input logic [7:0] p[$]);
        logic [7:0] s = l;
        foreach (p[i]) s = s ^ p[i];
        return s;
    endfunction

    task automatic drive_at(input int target, input logic [7:0] b);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        last_cyc = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] b);
        drive_at(cyc + 1, b);
    endtask

    function automatic int nxt(input bit gappy);
        if (gappy) return last_cyc + int'($urandom_range(1, TMO + 1));
        return last_cyc + 1;
    endfunction

    task automatic send_frame(input logic [7:0] lb, input logic [7:0] p[$],
                              input logic [7:0] cb, input bit gappy);
        send(8'hA5);
        drive_at(nxt(gappy), lb);
        foreach (p[i]) drive_at(nxt(gappy), p[i]);
        drive_at(nxt(gappy), cb);
    endtask

    task automatic snap();
        b_ok = n_ok; b_chk = n_chk; b_len = n_len; b_to = n_to; b_ovr = n_ovr;
        got.delete();
    endtask

    task automatic check_counts(input string tag, input int eok, input int echk,
                                input int elen, input int eto, input int eovr);
        compare({tag, "_ok"}, n_ok - b_ok, eok);
        compare({tag, "_errchk"}, n_chk - b_chk, echk);
        compare({tag, "_errlen"}, n_len - b_len, elen);
        compare({tag, "_errto"}, n_to - b_to, eto);
        compare({tag, "_errovr"}, n_ovr - b_ovr, eovr);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] p[$]);
        compare({tag, "_count"}, got.size(), p.size());
        for (int i = 0; i < p.size() && i < got.size(); i++)
            compare({tag, "_byte"}, got[i], {(i == p.size() - 1), p[i]});
    endtask

    task automatic wait_idle(input int nexp, input bit rnd, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(posedge clk);
            #1;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done = !busy && (got.size() >= nexp);
        end
        compare({tag, "_idle"}, done, 1);
        m_ready = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        compare({tag, "_mvalid"}, m_valid, 0);
        compare({tag, "_mlast"}, m_last, 0);
        compare({tag, "_mdata"}, m_data, 0);
        compare({tag, "_busy"}, busy, 0);
        compare({tag, "_pulses"},
                {frame_ok, err_chk, err_len, err_timeout, err_overrun}, 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero(tag);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p[$];
        logic [7:0] c;
        int n, b, cb;
        bit bad, rnd;

        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Nominal frame A5 03 11 22 33 03.
        p = '{8'h11, 8'h22, 8'h33};
        c = xsum(8'h03, p);
        compare("model_chk", c, 8'h03);
        snap();
        send_frame(8'h03, p, c, 1'b0);
        cb = last_cyc;
        wait_idle(3, 1'b0, "basic");
        check_counts("basic", 1, 0, 0, 0, 0);
        check_stream("basic", p);
        compare("basic_ok_cyc", ok_cyc, cb + 1);
        compare("basic_first_valid", first_v_cyc, ok_cyc + 1);
        compare("basic_drain_span", last_x_cyc - first_x_cyc, 2);

        // Checksum mismatch.
        snap();
        send_frame(8'h03, p, 8'h00, 1'b0);
        cb = last_cyc;
        wait_idle(0, 1'b0, "badchk");
        check_counts("badchk", 0, 1, 0, 0, 0);
        compare("badchk_noxfer", got.size(), 0);
        compare("badchk_cyc", chk_cyc, cb + 1);
        compare("badchk_busy", chk_busy, 0);

        // Length errors, then the largest legal frame.
        snap();
        send(8'hA5);
        send(8'h00);
        wait_idle(0, 1'b0, "len0");
        send(8'hA5);
        send(8'(MAXL + 1));
        wait_idle(0, 1'b0, "lenbig");
        check_counts("lenerr", 0, 0, 2, 0, 0);
        p = {};
        for (int i = 0; i < MAXL; i++) p.push_back(8'($urandom));
        snap();
        send_frame(8'(MAXL), p, xsum(8'(MAXL), p), 1'b0);
        wait_idle(MAXL, 1'b0, "maxlen");
        check_counts("maxlen", 1, 0, 0, 0, 0);
        check_stream("maxlen", p);

        // Inter-byte timeout: A5 02 11 then silence.
        snap();
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        b = last_cyc;
        for (int i = 0; i < int'(TMO) + 20 && n_to == b_to; i++) begin
            @(posedge clk);
            #1;
        end
        check_counts("timeout", 0, 0, 0, 1, 0);
        compare("timeout_cyc", to_cyc, b + int'(TMO) + 1);
        wait_idle(0, 1'b0, "timeout");

        // Byte landing exactly on the timeout boundary is accepted.
        p = '{8'h11, 8'h22};
        snap();
        send(8'hA5);
        send(8'h02);
        send(8'h11);
        drive_at(last_cyc + int'(TMO) + 1, 8'h22);
        send(xsum(8'h02, p));
        wait_idle(2, 1'b0, "edge");
        check_counts("edge", 1, 0, 0, 0, 0);
        check_stream("edge", p);

        // Overrun while stalled in DRAIN; payload must survive.
        p = '{8'h5A, 8'hA5, 8'h00, 8'hFF};
        snap();
        m_ready = 1'b0;
        send_frame(8'h04, p, xsum(8'h04, p), 1'b0);
        send(8'hA5);
        send(8'h04);
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare("ovr_hold_valid", m_valid, 1);
        compare("ovr_hold_data", m_data, 8'h5A);
        wait_idle(4, 1'b0, "ovr");
        check_counts("ovr", 1, 0, 0, 0, 2);
        check_stream("ovr", p);
        compare("ovr_stable", n_unstable, 0);

        // Reset mid-PAYLOAD.
        snap();
        send(8'hA5);
        send(8'h05);
        send(8'h01);
        send(8'h02);
        pulse_reset("rst_pay");
        check_counts("rst_pay", 0, 0, 0, 0, 0);

        // Reset mid-DRAIN.
        p = '{8'h10, 8'h20, 8'h30};
        snap();
        m_ready = 1'b0;
        send_frame(8'h03, p, xsum(8'h03, p), 1'b0);
        repeat (3) @(posedge clk);
        pulse_reset("rst_drain");
        check_counts("rst_drain", 1, 0, 0, 0, 0);
        compare("rst_drain_noxfer", got.size(), 0);
        m_ready = 1'b1;

        // Frame after reset.
        p = '{8'hC3, 8'h3C};
        snap();
        send_frame(8'h02, p, xsum(8'h02, p), 1'b0);
        wait_idle(2, 1'b0, "post_rst");
        check_counts("post_rst", 1, 0, 0, 0, 0);
        check_stream("post_rst", p);

        // Randomized frames with random gaps, corruption and back-pressure.
        for (int f = 0; f < 24; f++) begin
            n = int'($urandom_range(1, MAXL));
            p = {};
            for (int i = 0; i < n; i++) p.push_back(8'($urandom));
            bad = ($urandom_range(0, 3) == 0);
            c = xsum(8'(n), p);
            if (bad) c = c ^ 8'($urandom_range(1, 255));
            rnd = 1'($urandom_range(0, 1));
            snap();
            send_frame(8'(n), p, c, 1'b1);
            wait_idle(bad ? 0 : n, rnd, "rnd");
            check_counts("rnd", bad ? 0 : 1, bad ? 1 : 0, 0, 0, 0);
            if (bad) compare("rnd_noxfer", got.size(), 0);
            else check_stream("rnd", p);
        end

        compare("single_err_pulse", n_multi, 0);
        compare("stall_stable", n_unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
